// File: rtl/bv_match_sched_if.sv
// Bus bundle for bv_match_sched: priority-table config port, lookup request
// handshake and the result/status outputs.
//
// Lookup handshake: a request transfers on a rising clk edge where both
// lookup_valid and lookup_ready are high. The requester holds lookup_valid
// and lookup_bv stable until that edge. lookup_bv is sampled only on that
// edge. result_valid is a one-cycle pulse with no back-pressure, and the
// result fields hold their values until the next pulse.
interface bv_match_sched_if #(
  parameter int RULE_NUM = 64,
  parameter int PRIOR_W  = 8
);
  logic                cfg_wr;
  logic [7:0]          cfg_addr;
  logic [PRIOR_W-1:0]  cfg_data;
  logic                lookup_valid;
  logic [RULE_NUM-1:0] lookup_bv;
  logic                lookup_ready;
  logic                busy;
  logic                result_valid;
  logic                result_hit;
  logic [PRIOR_W-1:0]  result_prior;
  logic [7:0]          result_index;

  // Requester / configuration side
  modport master (
    output cfg_wr, cfg_addr, cfg_data, lookup_valid, lookup_bv,
    input  lookup_ready, busy, result_valid, result_hit, result_prior, result_index
  );

  // Scheduler side
  modport slave (
    input  cfg_wr, cfg_addr, cfg_data, lookup_valid, lookup_bv,
    output lookup_ready, busy, result_valid, result_hit, result_prior, result_index
  );
endinterface

// File: rtl/bv_match_sched.sv
// bv_match_sched: sequential priority resolver. Walks a latched match vector
// one rule per cycle through a single comparator and reports the matching
// rule with the highest priority (lowest index wins on a tie).
module bv_match_sched #(
  parameter int RULE_NUM = 64,
  parameter int PRIOR_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  bv_match_sched_if.slave     bus,
  output logic [1:0]          state_dbg
);

  localparam int         IDX_W      = (RULE_NUM > 1) ? $clog2(RULE_NUM) : 1;
  localparam logic [8:0] RULE_NUM_L = 9'(RULE_NUM);
  localparam logic [7:0] LAST_IDX   = 8'(RULE_NUM - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [RULE_NUM-1:0] bv_q, bv_d;
  logic [7:0]          scan_idx_q, scan_idx_d;
  logic                best_hit_q, best_hit_d;
  logic [PRIOR_W-1:0]  best_prior_q, best_prior_d;
  logic [7:0]          best_index_q, best_index_d;
  logic                res_hit_q, res_hit_d;
  logic [PRIOR_W-1:0]  res_prior_q, res_prior_d;
  logic [7:0]          res_index_q, res_index_d;
  logic [PRIOR_W-1:0]  tbl_q [RULE_NUM];
  logic [PRIOR_W-1:0]  tbl_d [RULE_NUM];

  // Shared compare stage: the entry currently addressed by scan_idx.
  // scan_idx never exceeds RULE_NUM-1, so the low bits address it fully.
  logic [IDX_W-1:0]    cur_idx;
  logic [PRIOR_W-1:0]  cur_prior;
  logic                cur_bit;
  logic                take;
  logic [IDX_W-1:0]    cfg_idx;
  logic                cfg_in_range;

  assign cur_idx      = scan_idx_q[IDX_W-1:0];
  assign cur_prior    = tbl_q[cur_idx];
  assign cur_bit      = bv_q[cur_idx];
  // Strict greater-than keeps the earlier (lower) index on equal priority.
  assign take         = cur_bit && (!best_hit_q || (cur_prior > best_prior_q));
  assign cfg_idx      = bus.cfg_addr[IDX_W-1:0];
  assign cfg_in_range = ({1'b0, bus.cfg_addr} < RULE_NUM_L);

  // Priority table update; writes are accepted in any state and the compare
  // in the same cycle still sees the old value.
  always_comb begin
    tbl_d = tbl_q;
    if (bus.cfg_wr && cfg_in_range) begin
      tbl_d[cfg_idx] = bus.cfg_data;
    end
  end

  // Next-state and datapath: accept in IDLE, walk one rule per cycle in SCAN,
  // publish the final best on the edge entering DONE.
  always_comb begin
    state_d      = state_q;
    bv_d         = bv_q;
    scan_idx_d   = scan_idx_q;
    best_hit_d   = best_hit_q;
    best_prior_d = best_prior_q;
    best_index_d = best_index_q;
    res_hit_d    = res_hit_q;
    res_prior_d  = res_prior_q;
    res_index_d  = res_index_q;

    case (state_q)
      IDLE: begin
        if (bus.lookup_valid) begin
          bv_d         = bus.lookup_bv;
          scan_idx_d   = '0;
          best_hit_d   = 1'b0;
          best_prior_d = '0;
          best_index_d = '0;
          state_d      = SCAN;
        end
      end
      SCAN: begin
        if (take) begin
          best_hit_d   = 1'b1;
          best_prior_d = cur_prior;
          best_index_d = scan_idx_q;
        end
        if (scan_idx_q == LAST_IDX) begin
          res_hit_d   = best_hit_d;
          res_prior_d = best_prior_d;
          res_index_d = best_index_d;
          state_d     = DONE;
        end else begin
          scan_idx_d = scan_idx_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, scan and table registers; reset clears everything including the table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bv_q         <= '0;
      scan_idx_q   <= '0;
      best_hit_q   <= 1'b0;
      best_prior_q <= '0;
      best_index_q <= '0;
      res_hit_q    <= 1'b0;
      res_prior_q  <= '0;
      res_index_q  <= '0;
      for (int i = 0; i < RULE_NUM; i++) begin
        tbl_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      bv_q         <= bv_d;
      scan_idx_q   <= scan_idx_d;
      best_hit_q   <= best_hit_d;
      best_prior_q <= best_prior_d;
      best_index_q <= best_index_d;
      res_hit_q    <= res_hit_d;
      res_prior_q  <= res_prior_d;
      res_index_q  <= res_index_d;
      tbl_q        <= tbl_d;
    end
  end

  assign bus.lookup_ready = (state_q == IDLE);
  assign bus.busy         = (state_q == SCAN);
  assign bus.result_valid = (state_q == DONE);
  assign bus.result_hit   = res_hit_q;
  assign bus.result_prior = res_prior_q;
  assign bus.result_index = res_index_q;
  assign state_dbg        = state_q;

endmodule
